slip_frame_tester: RTL and testbench
====================================

Name: slip_frame_tester

Overview:
Self-checking SLIP loopback exerciser; synthesizable successor to the fixed 21-byte incrementing bench.
- Drives the slip_tx byte interface with parametrised frames: length, count, inter-frame gap and data pattern are all configurable.
- Checks every frame returned on the slip_rx interface against an independent copy of the same pattern generator, and counts good and bad frames.
- Sits between slip_tx/slip_rx and board status logic (LEDs or register readout) for on-hardware VLC link tests.

Parameters:
FRAME_LEN, 21, payload bytes per frame (1..65535).
NUM_FRAMES, 0, frames to send; 0 means run continuously.
PATTERN, 0, 0 = incrementing; 1 = per-frame LFSR; 2 = SLIP special-character stress.
GAP_CYCLES, 0, idle cycles between the TX end-done and the next start.
TIMEOUT, 4096, cycles after the final TX end-done to wait for outstanding RX frames.
CNT_W, 16, width of the status counters.

Ports:
i_clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_enable  in  1  run request; level-sensitive
o_tx_start  out  1  one-cycle pulse that opens a frame
o_tx_end  out  1  one-cycle pulse that closes a frame
o_tx_dv  out  1  one-cycle pulse; o_tx_byte is valid
o_tx_byte  out  8  payload byte
i_tx_done  in  1  TX ready/accepted pulse, after start, after each byte, and after end
i_rx_started  in  1  RX frame-open pulse
i_rx_ended  in  1  RX frame-close pulse
i_rx_byte_done  in  1  RX byte-valid pulse
i_rx_byte  in  8  received byte
o_frames_tx  out  CNT_W  frames fully sent
o_frames_ok  out  CNT_W  frames received with correct length and content
o_frames_bad  out  CNT_W  frames received with a length or content error
o_err  out  1  one-cycle pulse on each bad-frame decision
o_busy  out  1  high whenever the TX FSM is not IDLE
o_done  out  1  sticky; run complete (only when NUM_FRAMES > 0)

Behaviour:
Reset and outputs
- Reset (synchronous, active-high, sampled on i_clk) clears all outputs, counters and FSMs to 0/IDLE/WAIT_START.
- Reset mid-frame aborts immediately; no end pulse is issued.
- All outputs are registered.

Pattern (byte k = 0..FRAME_LEN-1 of frame f, f = o_frames_tx value at frame start)
- PATTERN 0: (f + k) mod 256.
- PATTERN 1: 8-bit Fibonacci LFSR, taps 8,6,5,4. Seeded at each frame start with 0xA5 ^ f[7:0]; a seed of 0 is replaced by 0x01. Byte 0 is the seed; the LFSR steps once per byte.
- PATTERN 2: table {C0, DB, DC, DD, 00, FF} indexed by (f + k) mod 6.
- The RX checker uses its own generator instance. It latches its own frame index f_rx = o_frames_ok + o_frames_bad at i_rx_started.

TX FSM
- IDLE: if i_enable and not o_done, pulse o_tx_start and go to START_WAIT.
- START_WAIT: on i_tx_done, pulse o_tx_dv with byte 0 and go to DATA.
- DATA: on i_tx_done, if k == FRAME_LEN-1, pulse o_tx_end and go to END_WAIT; otherwise pulse o_tx_dv with byte k+1.
- END_WAIT: on i_tx_done, increment o_frames_tx, then go to GAP if GAP_CYCLES > 0, else IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Only one of start/dv/end pulses in any cycle. o_tx_byte holds its value between dv pulses.
- Dropping i_enable mid-frame: the current frame completes, then the FSM stops in IDLE.
- If NUM_FRAMES > 0 and o_frames_tx reaches NUM_FRAMES, no further starts are issued.

RX checker FSM
- WAIT_START: on i_rx_started, clear the byte count and mismatch flag, seed the generator, and go to IN_FRAME.
- WAIT_START: i_rx_byte_done and i_rx_ended are ignored.
- IN_FRAME, on i_rx_byte_done: compare i_rx_byte to the expected byte for the current count.
  - Set the mismatch flag on inequality.
  - Count bytes beyond FRAME_LEN as a length error; their content is not compared.
- IN_FRAME, on i_rx_ended:
  - If count == FRAME_LEN and no mismatch, increment o_frames_ok.
  - Otherwise increment o_frames_bad and pulse o_err.
  - Return to WAIT_START.
- IN_FRAME, i_rx_started before i_rx_ended: the open frame is decided bad, then a new frame opens in the same cycle.
- Simultaneous pulses in one cycle are processed in the order byte_done, ended, started.

Completion
- Condition: NUM_FRAMES > 0, o_frames_tx == NUM_FRAMES, and either (ok + bad == tx) or TIMEOUT cycles have elapsed since the last TX end-done.
- When the condition holds, o_done is set. o_done clears only on reset.
- All counters saturate at all-ones and do not wrap.

Test Plan:
1. Defaults, direct TX→RX loopback of the slip pair, NUM_FRAMES=3, PATTERN 0 → frame 1 payload is 01..15 hex. o_frames_tx = 3, ok = 3, bad = 0; o_done set; o_err never pulses.
2. PATTERN 2, FRAME_LEN=12, NUM_FRAMES=2 through real slip_tx/slip_rx → escaped C0/DB round-trip correctly. ok = 2, bad = 0.
3. Loopback model flips bit 0 of byte 5 in frame 1 only, NUM_FRAMES=3 → ok = 2, bad = 1, exactly one o_err pulse.
4. Model drops the last byte of frame 0 → bad = 1 from the length error. Model injects an extra byte → bad increments again.
5. Model drops i_rx_ended of the final frame, TIMEOUT=100 → o_done asserts within 100 cycles of the last end-done; ok + bad = NUM_FRAMES - 1.
6. Continuous mode, i_enable deasserted mid-frame, then reset asserted mid-frame in a second run:
   - After deassert: the frame completes with an end pulse, o_busy falls, o_frames_tx is stable.
   - After reset: everything is zero the next cycle, with no end pulse.

Source files
------------

// File: rtl/slip_frame_tester.sv
// slip_frame_tester: sends framed test traffic into a SLIP transmitter and
// checks each frame coming back from the SLIP receiver against a private copy
// of the same byte pattern. It counts frames sent, frames received intact and
// frames received damaged, and flags completion of a finite run.
module slip_frame_tester #(
  parameter int unsigned FRAME_LEN  = 21,
  parameter int unsigned NUM_FRAMES = 0,
  parameter int unsigned PATTERN    = 0,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_enable,
  output logic             o_tx_start,
  output logic             o_tx_end,
  output logic             o_tx_dv,
  output logic [7:0]       o_tx_byte,
  input  logic             i_tx_done,
  input  logic             i_rx_started,
  input  logic             i_rx_ended,
  input  logic             i_rx_byte_done,
  input  logic [7:0]       i_rx_byte,
  output logic [CNT_W-1:0] o_frames_tx,
  output logic [CNT_W-1:0] o_frames_ok,
  output logic [CNT_W-1:0] o_frames_bad,
  output logic             o_err,
  output logic             o_busy,
  output logic             o_done
);

  // Index of the last payload byte, the expected received length, and the
  // final count value of the inter-frame gap.
  localparam logic [15:0]      LAST_K       = 16'(FRAME_LEN - 1);
  localparam logic [16:0]      FRAME_LEN_C  = 17'(FRAME_LEN);
  localparam logic [31:0]      GAP_LAST     = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 32'd0;
  localparam logic [CNT_W-1:0] NUM_FRAMES_C = CNT_W'(NUM_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [16:0]      RX_CNT_MAX   = '1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START_WAIT,
    TX_DATA,
    TX_END_WAIT,
    TX_GAP
  } tx_state_e;

  typedef enum logic {
    RX_WAIT_START,
    RX_IN_FRAME
  } rx_state_e;

  // The generator state carries all three pattern flavours side by side. The
  // TX side and the RX checker each own one copy, so a fault in one path
  // cannot hide itself by corrupting the reference as well.
  typedef struct packed {
    logic [7:0] inc;
    logic [7:0] lfsr;
    logic [2:0] m6;
  } gen_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic gen_t gen_seed(input logic [31:0] f);
    gen_t g;
    g.inc  = f[7:0];
    g.lfsr = 8'hA5 ^ f[7:0];
    if (g.lfsr == 8'h00) begin
      g.lfsr = 8'h01;
    end
    g.m6   = 3'(f % 32'd6);
    return g;
  endfunction

  function automatic gen_t gen_next(input gen_t g);
    gen_t n;
    n.inc  = g.inc + 8'd1;
    n.lfsr = lfsr_step(g.lfsr);
    n.m6   = (g.m6 == 3'd5) ? 3'd0 : g.m6 + 3'd1;
    return n;
  endfunction

  function automatic logic [7:0] gen_byte(input gen_t g);
    logic [7:0] b;
    b = g.inc;
    case (PATTERN)
      1: b = g.lfsr;
      2: begin
        case (g.m6)
          3'd0:    b = 8'hC0;
          3'd1:    b = 8'hDB;
          3'd2:    b = 8'hDC;
          3'd3:    b = 8'hDD;
          3'd4:    b = 8'h00;
          default: b = 8'hFF;
        endcase
      end
      default: b = g.inc;
    endcase
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  tx_state_e        tx_state_q, tx_state_d;
  logic [15:0]      k_q, k_d;
  logic [31:0]      gap_cnt_q, gap_cnt_d;
  gen_t             tx_gen_q, tx_gen_d;
  logic             tx_start_q, tx_start_d;
  logic             tx_dv_q, tx_dv_d;
  logic             tx_end_q, tx_end_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [CNT_W-1:0] frames_tx_q, frames_tx_d;
  logic             busy_q, busy_d;
  logic             end_done;
  logic             limit_hit;

  rx_state_e        rx_state_q, rx_state_d;
  logic [16:0]      rx_cnt_q, rx_cnt_d;
  logic             mismatch_q, mismatch_d;
  gen_t             rx_gen_q, rx_gen_d;
  logic [CNT_W-1:0] frames_ok_q, frames_ok_d;
  logic [CNT_W-1:0] frames_bad_q, frames_bad_d;
  logic             err_q, err_d;
  logic             rx_open;
  logic             rx_good;

  logic [31:0]      to_cnt_q, to_cnt_d;
  logic             done_q, done_d;
  logic [CNT_W:0]   rx_total;

  assign limit_hit = (NUM_FRAMES != 0) && (frames_tx_q == NUM_FRAMES_C);

  // TX sequencer: open a frame, feed payload bytes one per accepted handshake,
  // close the frame, then optionally idle for the configured gap.
  always_comb begin
    tx_state_d  = tx_state_q;
    k_d         = k_q;
    gap_cnt_d   = gap_cnt_q;
    tx_gen_d    = tx_gen_q;
    tx_start_d  = 1'b0;
    tx_dv_d     = 1'b0;
    tx_end_d    = 1'b0;
    tx_byte_d   = tx_byte_q;
    frames_tx_d = frames_tx_q;
    end_done    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (i_enable && !done_q && !limit_hit) begin
          tx_start_d = 1'b1;
          tx_gen_d   = gen_seed(32'(frames_tx_q));
          tx_state_d = TX_START_WAIT;
        end
      end
      TX_START_WAIT: begin
        if (i_tx_done) begin
          tx_dv_d    = 1'b1;
          tx_byte_d  = gen_byte(tx_gen_q);
          tx_gen_d   = gen_next(tx_gen_q);
          k_d        = 16'd0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (i_tx_done) begin
          if (k_q == LAST_K) begin
            tx_end_d   = 1'b1;
            tx_state_d = TX_END_WAIT;
          end else begin
            tx_dv_d   = 1'b1;
            tx_byte_d = gen_byte(tx_gen_q);
            tx_gen_d  = gen_next(tx_gen_q);
            k_d       = k_q + 16'd1;
          end
        end
      end
      TX_END_WAIT: begin
        if (i_tx_done) begin
          end_done    = 1'b1;
          frames_tx_d = sat_inc(frames_tx_q);
          if (GAP_CYCLES > 0) begin
            gap_cnt_d  = 32'd0;
            tx_state_d = TX_GAP;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      TX_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          tx_state_d = TX_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    busy_d = (tx_state_d != TX_IDLE);
  end

  // TX state and registered TX-side outputs.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      k_q         <= 16'd0;
      gap_cnt_q   <= 32'd0;
      tx_gen_q    <= '0;
      tx_start_q  <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_end_q    <= 1'b0;
      tx_byte_q   <= 8'd0;
      frames_tx_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      k_q         <= k_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_gen_q    <= tx_gen_d;
      tx_start_q  <= tx_start_d;
      tx_dv_q     <= tx_dv_d;
      tx_end_q    <= tx_end_d;
      tx_byte_q   <= tx_byte_d;
      frames_tx_q <= frames_tx_d;
      busy_q      <= busy_d;
    end
  end

  // RX checker: same-cycle events are handled as byte, then close, then open,
  // so a closing byte still counts and a reopening frame seeds from the
  // counters as they stand after the close decision.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    mismatch_d   = mismatch_q;
    rx_gen_d     = rx_gen_q;
    frames_ok_d  = frames_ok_q;
    frames_bad_d = frames_bad_q;
    err_d        = 1'b0;
    rx_good      = 1'b0;
    rx_open      = (rx_state_q == RX_IN_FRAME);
    if (rx_open && i_rx_byte_done) begin
      if (rx_cnt_q < FRAME_LEN_C) begin
        if (i_rx_byte != gen_byte(rx_gen_q)) begin
          mismatch_d = 1'b1;
        end
        rx_gen_d = gen_next(rx_gen_q);
      end
      if (rx_cnt_q != RX_CNT_MAX) begin
        rx_cnt_d = rx_cnt_q + 17'd1;
      end
    end
    if (rx_open && i_rx_ended) begin
      rx_good = (rx_cnt_d == FRAME_LEN_C) && !mismatch_d;
      if (rx_good) begin
        frames_ok_d = sat_inc(frames_ok_q);
      end else begin
        frames_bad_d = sat_inc(frames_bad_q);
        err_d        = 1'b1;
      end
      rx_open    = 1'b0;
      rx_state_d = RX_WAIT_START;
    end
    if (i_rx_started) begin
      if (rx_open) begin
        frames_bad_d = sat_inc(frames_bad_q);
        err_d        = 1'b1;
      end
      rx_cnt_d   = 17'd0;
      mismatch_d = 1'b0;
      rx_gen_d   = gen_seed(32'(frames_ok_d) + 32'(frames_bad_d));
      rx_state_d = RX_IN_FRAME;
    end
  end

  // RX checker state and registered result counters.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      rx_state_q   <= RX_WAIT_START;
      rx_cnt_q     <= 17'd0;
      mismatch_q   <= 1'b0;
      rx_gen_q     <= '0;
      frames_ok_q  <= '0;
      frames_bad_q <= '0;
      err_q        <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      mismatch_q   <= mismatch_d;
      rx_gen_q     <= rx_gen_d;
      frames_ok_q  <= frames_ok_d;
      frames_bad_q <= frames_bad_d;
      err_q        <= err_d;
    end
  end

  // Completion: a finite run is finished once every sent frame has been
  // judged, or once the receive side has been silent long enough after the
  // last frame went out. The timer starts at 1 on the end handshake so that
  // the done flag lands exactly TIMEOUT cycles after it.
  assign rx_total = {1'b0, frames_ok_q} + {1'b0, frames_bad_q};

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (end_done) begin
      to_cnt_d = 32'd1;
    end else if (to_cnt_q < TIMEOUT) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
    done_d = done_q;
    if (limit_hit && ((rx_total == {1'b0, frames_tx_q}) || (to_cnt_q >= TIMEOUT))) begin
      done_d = 1'b1;
    end
  end

  // Completion timer and sticky done flag.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      to_cnt_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      done_q   <= done_d;
    end
  end

  assign o_tx_start   = tx_start_q;
  assign o_tx_end     = tx_end_q;
  assign o_tx_dv      = tx_dv_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_frames_tx  = frames_tx_q;
  assign o_frames_ok  = frames_ok_q;
  assign o_frames_bad = frames_bad_q;
  assign o_err        = err_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_slip_frame_tester.sv
// Bench for slip_frame_tester: three instances (incrementing, LFSR and
// special-character patterns), each closed through a behavioural SLIP
// loopback that can corrupt, drop or add traffic on demand.
`timescale 1ns/1ps
module tb_slip_frame_tester;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable [3];
  int   flipFrame [3];
  int   flipByte [3];
  int   dropLastFrame [3];
  int   extraFrame [3];
  int   dropEndFrame [3];

  logic        doneArr [3];
  logic        busyArr [3];
  logic [15:0] txArr [3];
  logic [15:0] okArr [3];
  logic [15:0] badArr [3];

  int cycleCount = 0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount = cycleCount + 1;

  for (genvar g = 0; g < 3; g++) begin : gen_inst
    localparam int FL  = (g == 0) ? 21 : ((g == 1) ? 5 : 12);
    localparam int NF  = (g == 0) ? 3 : ((g == 1) ? 0 : 2);
    localparam int GAP = (g == 1) ? 3 : ((g == 2) ? 1 : 0);
    localparam int TO  = (g == 0) ? 100 : 4096;

    logic        txStart, txEnd, txDv, err, busy, done;
    logic [7:0]  txByte;
    logic        txDone = 1'b0;
    logic        rxStarted = 1'b0;
    logic        rxEnded = 1'b0;
    logic        rxByteDone = 1'b0;
    logic [7:0]  rxByte = 8'h00;
    logic [15:0] framesTx, framesOk, framesBad;

    int startCount = 0;
    int endCount = 0;
    int errCount = 0;
    int byteIdx = 0;
    int lastEndCycle = 0;
    logic [7:0] cap [4][32];
    logic pend = 1'b0;
    int pendKind = 0;
    int pendDelay = 0;
    logic [7:0] pendByte = 8'h00;

    slip_frame_tester #(
      .FRAME_LEN(FL), .NUM_FRAMES(NF), .PATTERN(g),
      .GAP_CYCLES(GAP), .TIMEOUT(TO), .CNT_W(16)
    ) dut (
      .i_clk(clock), .reset(reset), .i_enable(enable[g]),
      .o_tx_start(txStart), .o_tx_end(txEnd), .o_tx_dv(txDv), .o_tx_byte(txByte),
      .i_tx_done(txDone), .i_rx_started(rxStarted), .i_rx_ended(rxEnded),
      .i_rx_byte_done(rxByteDone), .i_rx_byte(rxByte),
      .o_frames_tx(framesTx), .o_frames_ok(framesOk), .o_frames_bad(framesBad),
      .o_err(err), .o_busy(busy), .o_done(done)
    );

    assign doneArr[g] = done;
    assign busyArr[g] = busy;
    assign txArr[g]   = framesTx;
    assign okArr[g]   = framesOk;
    assign badArr[g]  = framesBad;

    // Loopback model: acknowledges every TX pulse and replays it on the RX
    // side; escaped characters take one extra cycle, as on a real link.
    always @(negedge clock) begin : loopback
      txDone = 1'b0;
      rxStarted = 1'b0;
      rxEnded = 1'b0;
      rxByteDone = 1'b0;
      if (reset) begin
        startCount = 0;
        endCount = 0;
        errCount = 0;
        byteIdx = 0;
        pend = 1'b0;
      end else begin
        if (err) errCount = errCount + 1;
        if (txStart) begin
          startCount = startCount + 1;
          byteIdx = 0;
          pend = 1'b1;
          pendKind = 0;
          pendDelay = 0;
        end else if (txDv) begin
          if (startCount >= 1 && startCount <= 4 && byteIdx < 32) cap[startCount-1][byteIdx] = txByte;
          pend = 1'b1;
          pendKind = 1;
          pendByte = txByte;
          pendDelay = (txByte == 8'hC0 || txByte == 8'hDB) ? 1 : 0;
          if (startCount - 1 == flipFrame[g] && byteIdx == flipByte[g]) pendByte = pendByte ^ 8'h01;
          if (startCount - 1 == dropLastFrame[g] && byteIdx == FL - 1) pendKind = 3;
          byteIdx = byteIdx + 1;
        end else if (txEnd) begin
          endCount = endCount + 1;
          pend = 1'b1;
          pendKind = 2;
          pendDelay = 0;
        end
        if (pend) begin
          if (pendDelay > 0) begin
            pendDelay = pendDelay - 1;
          end else begin
            pend = 1'b0;
            txDone = 1'b1;
            case (pendKind)
              0: rxStarted = 1'b1;
              1: begin
                rxByteDone = 1'b1;
                rxByte = pendByte;
              end
              2: begin
                lastEndCycle = cycleCount + 1;
                if (startCount - 1 == extraFrame[g]) begin
                  rxByteDone = 1'b1;
                  rxByte = 8'h55;
                end
                if (startCount - 1 != dropEndFrame[g]) rxEnded = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clock);
    for (int i = 0; i < 3; i++) enable[i] = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int g, input int flipF, input int flipB,
                               input int dropLastF, input int extraF, input int dropEndF);
    flipFrame[g] = flipF;
    flipByte[g] = flipB;
    dropLastFrame[g] = dropLastF;
    extraFrame[g] = extraF;
    dropEndFrame[g] = dropEndF;
    enable[g] = 1'b1;
  endtask

  task automatic waitDone(input int g, input int budget);
    for (int i = 0; i < budget && doneArr[g] !== 1'b1; i++) @(negedge clock);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: run did not reach its end, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int elapsed;
    logic sawEnd;
    for (int i = 0; i < 3; i++) begin
      enable[i] = 1'b0;
      flipFrame[i] = -1;
      flipByte[i] = -1;
      dropLastFrame[i] = -1;
      extraFrame[i] = -1;
      dropEndFrame[i] = -1;
    end
    repeat (3) @(negedge clock);
    checkOutput("reset tx", txArr[0], 0);
    checkOutput("reset ok", okArr[0], 0);
    checkOutput("reset bad", badArr[0], 0);
    checkOutput("reset busy", busyArr[0], 0);
    checkOutput("reset done", doneArr[0], 0);
    checkOutput("reset pulses", {gen_inst[0].txStart, gen_inst[0].txDv, gen_inst[0].txEnd, gen_inst[0].err}, 0);
    reset = 1'b0;

    // Clean incrementing run.
    applyStimulus(0, -1, -1, -1, -1, -1);
    waitDone(0, 400);
    checkOutput("t1 done", doneArr[0], 1);
    checkOutput("t1 tx", txArr[0], 3);
    checkOutput("t1 ok", okArr[0], 3);
    checkOutput("t1 bad", badArr[0], 0);
    checkOutput("t1 err pulses", gen_inst[0].errCount, 0);
    checkOutput("t1 f0 byte0", gen_inst[0].cap[0][0], 8'h00);
    checkOutput("t1 f1 byte0", gen_inst[0].cap[1][0], 8'h01);
    checkOutput("t1 f1 byte20", gen_inst[0].cap[1][20], 8'h15);
    checkOutput("t1 f2 byte7", gen_inst[0].cap[2][7], 8'h09);
    repeat (20) @(negedge clock);
    checkOutput("t1 no extra start", gen_inst[0].startCount, 3);
    checkOutput("t1 idle", busyArr[0], 0);

    // One flipped bit in frame 1.
    applyReset();
    applyStimulus(0, 1, 5, -1, -1, -1);
    waitDone(0, 400);
    checkOutput("t3 done", doneArr[0], 1);
    checkOutput("t3 ok", okArr[0], 2);
    checkOutput("t3 bad", badArr[0], 1);
    checkOutput("t3 err pulses", gen_inst[0].errCount, 1);

    // Short frame 0, long frame 2.
    applyReset();
    applyStimulus(0, -1, -1, 0, 2, -1);
    waitDone(0, 400);
    checkOutput("t4 done", doneArr[0], 1);
    checkOutput("t4 ok", okArr[0], 1);
    checkOutput("t4 bad", badArr[0], 2);
    checkOutput("t4 err pulses", gen_inst[0].errCount, 2);

    // Final frame never closes; completion relies on the timeout.
    applyReset();
    applyStimulus(0, -1, -1, -1, -1, 2);
    waitDone(0, 400);
    elapsed = cycleCount - gen_inst[0].lastEndCycle;
    checkOutput("t5 done", doneArr[0], 1);
    checkOutput("t5 ok", okArr[0], 2);
    checkOutput("t5 bad", badArr[0], 0);
    checkOutput("t5 timeout window", (elapsed >= 90 && elapsed <= 100) ? 1 : 0, 1);

    // Special-character pattern.
    applyReset();
    applyStimulus(2, -1, -1, -1, -1, -1);
    waitDone(2, 400);
    checkOutput("t2 done", doneArr[2], 1);
    checkOutput("t2 tx", txArr[2], 2);
    checkOutput("t2 ok", okArr[2], 2);
    checkOutput("t2 bad", badArr[2], 0);
    checkOutput("t2 f0 byte0", gen_inst[2].cap[0][0], 8'hC0);
    checkOutput("t2 f0 byte11", gen_inst[2].cap[0][11], 8'hFF);
    checkOutput("t2 f1 byte0", gen_inst[2].cap[1][0], 8'hDB);
    checkOutput("t2 f1 byte5", gen_inst[2].cap[1][5], 8'hC0);

    // Continuous LFSR run, enable dropped in the middle of frame 2.
    applyReset();
    applyStimulus(1, -1, -1, -1, -1, -1);
    for (int i = 0; i < 600 && !(gen_inst[1].startCount == 3 && gen_inst[1].byteIdx == 2); i++) @(negedge clock);
    checkOutput("t6 reached frame 2", gen_inst[1].startCount, 3);
    enable[1] = 1'b0;
    for (int i = 0; i < 100 && busyArr[1] !== 1'b0; i++) @(negedge clock);
    checkOutput("t6 busy fell", busyArr[1], 0);
    checkOutput("t6 end pulses", gen_inst[1].endCount, 3);
    checkOutput("t6 tx", txArr[1], 3);
    checkOutput("t6 ok", okArr[1], 3);
    checkOutput("t6 bad", badArr[1], 0);
    repeat (20) @(negedge clock);
    checkOutput("t6 tx stable", txArr[1], 3);
    checkOutput("t6 no restart", gen_inst[1].startCount, 3);
    checkOutput("t6 f0 byte0", gen_inst[1].cap[0][0], 8'hA5);
    checkOutput("t6 f0 byte1", gen_inst[1].cap[0][1], 8'h4A);
    checkOutput("t6 f0 byte2", gen_inst[1].cap[0][2], 8'h95);
    checkOutput("t6 f0 byte3", gen_inst[1].cap[0][3], 8'h2A);
    checkOutput("t6 f1 byte0", gen_inst[1].cap[1][0], 8'hA4);
    checkOutput("t6 f2 byte0", gen_inst[1].cap[2][0], 8'hA7);

    // Second run, reset in the middle of a frame.
    enable[1] = 1'b1;
    for (int i = 0; i < 200 && !(gen_inst[1].startCount == 4 && gen_inst[1].byteIdx == 2); i++) @(negedge clock);
    checkOutput("t6 reached frame 3", gen_inst[1].startCount, 4);
    reset = 1'b1;
    enable[1] = 1'b0;
    sawEnd = 1'b0;
    @(negedge clock);
    checkOutput("t6 rst tx", txArr[1], 0);
    checkOutput("t6 rst ok", okArr[1], 0);
    checkOutput("t6 rst bad", badArr[1], 0);
    checkOutput("t6 rst busy", busyArr[1], 0);
    checkOutput("t6 rst byte", gen_inst[1].txByte, 0);
    checkOutput("t6 rst pulses", {gen_inst[1].txStart, gen_inst[1].txDv, gen_inst[1].txEnd, gen_inst[1].err}, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sawEnd = sawEnd | gen_inst[1].txEnd;
      @(negedge clock);
    end
    checkOutput("t6 no end after reset", sawEnd, 0);
    checkOutput("t6 idle after reset", busyArr[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
